// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD  = 3'd0,
        SRC_STEP  = 3'd1,
        SRC_REDIR = 3'd2,
        SRC_TRAP  = 3'd3,
        SRC_ERET  = 3'd4
    } pc_src_e;

    localparam logic [31:0] DEF_START_ADDR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;
    localparam int unsigned DEF_STEP       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority select of the next-PC source; exception sources are
// honoured only when PC_SEQ_EXC_EN is defined.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic              ena,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic              in_handler,
    output pc_src_e           src,
    output logic              misalign_hit
);

    logic misaligned;

    assign misaligned = redir_valid && (|redir_target[ALIGN_BITS-1:0]);

`ifdef PC_SEQ_EXC_EN
    always_comb begin
        src          = SRC_HOLD;
        misalign_hit = 1'b0;
        if (exc_req) begin
            src = SRC_TRAP;
        end else if (misaligned) begin
            src          = SRC_TRAP;
            misalign_hit = 1'b1;
        end else if (eret && in_handler) begin
            src = SRC_ERET;
        end else if (redir_valid) begin
            src = SRC_REDIR;
        end else if (ena) begin
            src = SRC_STEP;
        end
    end
`else
    logic unused_exc;
    assign unused_exc = exc_req ^ eret ^ in_handler;

    // Without exception support a misaligned redirect is still taken; the top
    // clears the low bits of the target.
    always_comb begin
        src          = SRC_HOLD;
        misalign_hit = misaligned;
        if (redir_valid) begin
            src = SRC_REDIR;
        end else if (ena) begin
            src = SRC_STEP;
        end
    end
`endif

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer with EPC, RUN/HANDLER trap FSM and double-fault flag.
// Exception support is built only when PC_SEQ_EXC_EN is defined.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
    parameter int unsigned       STEP       = DEF_STEP,
    parameter int unsigned       ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic              in_handler,
    output logic              misalign,
    output logic              double_fault
);

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    pc_src_e           src;
    logic              misalign_hit;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] aligned_target;

    assign aligned_target = {redir_target[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

    pc_next_sel #(
        .ADDR_W    (ADDR_W),
        .ALIGN_BITS(ALIGN_BITS)
    ) u_next_sel (
        .ena         (ena),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .in_handler  (in_handler),
        .src         (src),
        .misalign_hit(misalign_hit)
    );

`ifdef PC_SEQ_EXC_EN
    pc_state_e         state, state_d;
    logic [ADDR_W-1:0] epc_d;
    logic              df_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_d;
        end
    end

    // A trap taken while already in HANDLER keeps the first return address.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        epc_d   = epc;
        df_d    = double_fault;
        case (src)
            SRC_STEP:  pc_d = pc + STEP_INC;
            SRC_REDIR: pc_d = aligned_target;
            SRC_TRAP: begin
                pc_d    = EXC_VECTOR;
                state_d = ST_HANDLER;
                if (state == ST_RUN) begin
                    epc_d = pc;
                end else begin
                    df_d = 1'b1;
                end
            end
            SRC_ERET: begin
                pc_d    = epc;
                state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc          <= '0;
            double_fault <= 1'b0;
        end else begin
            epc          <= epc_d;
            double_fault <= df_d;
        end
    end

    assign in_handler = (state == ST_HANDLER);
`else
    always_comb begin
        pc_d = pc;
        case (src)
            SRC_STEP:  pc_d = pc + STEP_INC;
            SRC_REDIR: pc_d = aligned_target;
            default: ;
        endcase
    end

    assign epc          = '0;
    assign in_handler   = 1'b0;
    assign double_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= START_ADDR;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_d;
            misalign <= misalign_hit;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench: a 32-bit and an 8-bit sequencer share stimulus; a reference
// model pushes expected snapshots and a monitor pops and compares them.
module tb_pc_seq_unit;

`ifdef PC_SEQ_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct {
        longint pc;
        longint epc;
        bit     h;
        bit     m;
        bit     d;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;

    logic [31:0] pc_a, epc_a;
    logic        h_a, m_a, d_a;
    logic [7:0]  pc_b, epc_b;
    logic        h_b, m_b, d_b;

    int total = 0;
    int bad   = 0;

    snap_t q0[$];
    snap_t q1[$];
    event  chk;

    // Reference model state, index 0 = 32-bit instance, 1 = 8-bit instance.
    longint mpc[2], mepc[2];
    bit     mh[2], mm[2], md[2];
    longint p_start[2] = '{64'h0040_0000, 64'hF8};
    longint p_vec[2]   = '{64'h0040_0004, 64'h04};
    longint p_mask[2]  = '{64'hFFFF_FFFF, 64'hFF};

    always #5 clk = ~clk;

    pc_seq_unit u_dut_a (
        .clk(clk), .rst(rst), .ena(ena), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_req(exc_req), .eret(eret),
        .pc(pc_a), .epc(epc_a), .in_handler(h_a), .misalign(m_a),
        .double_fault(d_a)
    );

    pc_seq_unit #(
        .ADDR_W(8), .START_ADDR(8'hF8), .EXC_VECTOR(8'h04), .STEP(4), .ALIGN_BITS(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena), .redir_valid(redir_valid),
        .redir_target(redir_target[7:0]), .exc_req(exc_req), .eret(eret),
        .pc(pc_b), .epc(epc_b), .in_handler(h_b), .misalign(m_b),
        .double_fault(d_b)
    );

    function automatic snap_t snap(int i);
        snap_t s;
        s.pc = mpc[i]; s.epc = mepc[i]; s.h = mh[i]; s.m = mm[i]; s.d = md[i];
        return s;
    endfunction

    task automatic push_all();
        q0.push_back(snap(0));
        q1.push_back(snap(1));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mpc[i] = p_start[i]; mepc[i] = 0; mh[i] = 0; mm[i] = 0; md[i] = 0;
        end
    endtask

    task automatic model_trap(int i);
        if (!mh[i]) mepc[i] = mpc[i];
        else        md[i] = 1;
        mh[i]  = 1;
        mpc[i] = p_vec[i];
    endtask

    task automatic model_edge(bit e, bit rv, longint rt_full, bit ex, bit er);
        for (int i = 0; i < 2; i++) begin
            longint rt = rt_full & p_mask[i];
            bit mis = rv && (rt % 4 != 0);
            mm[i] = 0;
            if (EXC_EN && ex) begin
                model_trap(i);
            end else if (mis) begin
                mm[i] = 1;
                if (EXC_EN) model_trap(i);
                else        mpc[i] = rt - (rt % 4);
            end else if (EXC_EN && er && mh[i]) begin
                mpc[i] = mepc[i];
                mh[i]  = 0;
            end else if (rv) begin
                mpc[i] = rt;
            end else if (e) begin
                mpc[i] = (mpc[i] + 4) & p_mask[i];
            end
        end
    endtask

    task automatic cyc(bit e, bit rv, logic [31:0] rt, bit ex, bit er);
        @(negedge clk);
        ena = e; redir_valid = rv; redir_target = rt; exc_req = ex; eret = er;
        model_edge(e, rv, longint'(rt), ex, er);
        push_all();
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        ena = 0; redir_valid = 0; exc_req = 0; eret = 0;
        #1;
        model_reset();
        push_all();
        rst = 1'b1;
        #2 rst = 1'b0;
        model_edge(0, 0, 0, 0, 0);
        push_all();
    endtask

    task automatic cmp(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk or posedge rst or chk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                cmp("pc_a", longint'(pc_a), e.pc);
                cmp("epc_a", longint'(epc_a), e.epc);
                cmp("in_handler_a", longint'(h_a), longint'(e.h));
                cmp("misalign_a", longint'(m_a), longint'(e.m));
                cmp("double_fault_a", longint'(d_a), longint'(e.d));
                e = q1.pop_front();
                cmp("pc_b", longint'(pc_b), e.pc);
                cmp("epc_b", longint'(epc_b), e.epc);
                cmp("in_handler_b", longint'(h_b), longint'(e.h));
                cmp("misalign_b", longint'(m_b), longint'(e.m));
                cmp("double_fault_b", longint'(d_b), longint'(e.d));
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        model_reset();
        push_all();
        -> chk;
        #3 rst = 1'b0;
        model_edge(0, 0, 0, 0, 0);
        push_all();

        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0040_0100, 0, 0);
        cyc(0, 1, 32'h0040_0102, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 32'h0040_0020, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        rst_pulse();
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        rst_pulse();
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst_pulse();
            end else begin
                logic [31:0] t;
                t = 32'h0040_0000 + 32'($urandom_range(0, 255));
                cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25, t,
                    $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20);
            end
        end
        cyc(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the fetch stage of the pipelined CPU. It holds the fetch address, advances it by a fixed step, and accepts stall, branch/jump redirect, exception entry and exception return. It keeps an exception PC (EPC), a two-state trap FSM and double-fault detection. It sits between the next-PC logic and instruction memory, and replaces the plain enable-gated PC register.

## Interface
Parameters:
- ADDR_W, 32: address width in bits.
- START_ADDR, 32'h00400000: PC value on reset.
- EXC_VECTOR, 32'h00400004: handler entry address.
- STEP, 4: sequential increment in bytes.
- ALIGN_BITS, 2: low target bits that must be zero.

Ports:
- clk  in  1: the only clock; all state changes on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- ena  in  1: advance enable; 0 = stall (PC holds).
- redir_valid  in  1: branch/jump taken this cycle.
- redir_target  in  ADDR_W: redirect destination.
- exc_req  in  1: exception request from a later stage.
- eret  in  1: return from exception.
- pc  out  ADDR_W: current fetch address (registered).
- epc  out  ADDR_W: saved return address (registered).
- in_handler  out  1: FSM is in HANDLER.
- misalign  out  1: one-cycle pulse; a misaligned redirect was converted to a trap.
- double_fault  out  1: sticky; cleared only by rst.

## Operation
- Reset values: pc = START_ADDR, epc = 0, FSM = RUN, in_handler = 0, misalign = 0, double_fault = 0.
- Per-edge next-PC priority, highest first:
  - exc_req
  - misaligned redirect (redir_valid with redir_target[ALIGN_BITS-1:0] != 0)
  - eret (only while in HANDLER)
  - aligned redirect
  - ena
  - hold
- Exceptions, eret and redirects take effect regardless of ena. ena gates only the sequential step.
- Sequential step: pc <= pc + STEP, modulo 2^ADDR_W. The all-ones region wraps to 0 with no flag.
- Trap entry (exc_req, or a misaligned redirect) in RUN:
  - pc <= EXC_VECTOR
  - epc <= pc
  - FSM -> HANDLER
  - A misaligned redirect also pulses misalign for one cycle.
- Trap entry in HANDLER:
  - pc <= EXC_VECTOR
  - epc unchanged
  - double_fault <= 1
  - FSM stays in HANDLER
- eret in HANDLER, with no trap entry the same edge: pc <= epc, FSM -> RUN.
- eret in RUN has no effect; the lower-priority sources apply.
- exc_req together with eret: exc_req wins. FSM stays in or enters HANDLER; epc follows the rules above.
- FSM states: RUN and HANDLER only. Transitions occur solely as listed above.

## Timing
- pc is a register. A request sampled at edge N is visible on pc after edge N (one-cycle latency). There is no combinational path from inputs to pc.
- epc, in_handler, misalign and double_fault update on the same edge as pc.
- misalign is high for exactly the cycle following the converting edge.
- rst asserted mid-operation forces all reset values immediately. It discards pending state, including HANDLER and double_fault. Release takes effect at the first edge after rst falls.
- A stall (ena = 0) with no other request holds pc indefinitely.

## Configuration
- Macro PC_SEQ_EXC_EN.
- Defined: full behaviour as above.
- Undefined:
  - exc_req and eret are ignored.
  - FSM is fixed at RUN; epc, in_handler and double_fault are tied to 0.
  - A misaligned redirect is taken as a normal redirect with the low ALIGN_BITS forced to 0; misalign still pulses.

## Structure
- Shared package pc_pkg holds:
  - the FSM state typedef (RUN, HANDLER)
  - default START_ADDR, EXC_VECTOR and STEP constants
  - the next-PC source enum (HOLD, STEP, REDIR, TRAP, ERET)
- One natural sub-module: pc_next_sel. It is combinational priority select producing the source enum and the misaligned flag. The top keeps all registers and the FSM.

## Test plan
- Reset, then ena = 1 for 3 cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C. Then ena = 0 for 2 cycles -> pc holds 0x0040000C.
- Stall with a redirect: ena = 0, redir_valid = 1, redir_target = 0x00400100 -> next pc = 0x00400100. A redirect to 0x00400102 -> pc = 0x00400004, epc = previous pc, misalign pulses 1 cycle, in_handler = 1.
- At pc = 0x00400020, exc_req -> pc = 0x00400004, epc = 0x00400020. Two steps later, eret -> pc = 0x00400020, in_handler = 0.
- In HANDLER with epc = 0x00400020, exc_req again -> double_fault = 1, epc stays 0x00400020, pc = 0x00400004. Same-cycle exc_req + eret -> pc = 0x00400004, FSM remains HANDLER.
- ADDR_W = 8, START_ADDR = 8'hF8, STEP = 4 -> pc F8, FC, 00. Then eret in RUN -> ignored, pc = 04.
- rst pulsed mid-cycle while in HANDLER with double_fault = 1 -> immediately pc = START_ADDR, all flags 0. With PC_SEQ_EXC_EN undefined, exc_req has no effect and epc reads 0.
